seq_detector_param: RTL and testbench
=====================================

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 SHALL have parameter DW, default 4, digit width in bits.
REQ-002 SHALL have parameter MAXLEN, default 8, maximum pattern length in digits; MAXLEN >= 4.
REQ-003 SHALL have parameter CNTW, default 8, match counter width.
REQ-004 SHALL have port clock  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  digit qualifier.
REQ-007 SHALL have port number  input  DW  input digit, sampled when in_valid=1.
REQ-008 SHALL have port cfg_we  input  1  configuration write strobe.
REQ-009 SHALL have port cfg_idx  input  clog2(MAXLEN)  pattern slot written; slot 0 is the first (oldest) digit of the pattern.
REQ-010 SHALL have port cfg_digit  input  DW  digit written to slot cfg_idx.
REQ-011 SHALL have port cfg_len  input  clog2(MAXLEN)+1  pattern length loaded with cfg_we.
REQ-012 SHALL have port cfg_overlap  input  1  detection mode loaded with cfg_we: 1 = overlapping, 0 = non-overlapping.
REQ-013 SHALL have port cnt_clr  input  1  synchronous clear of match_count.
REQ-014 SHALL have port pattern  output  1  registered one-cycle match pulse.
REQ-015 SHALL have port match_count  output  CNTW  saturating count of matches.
REQ-016 SHALL have port fill  output  clog2(MAXLEN)+1  number of valid digits accumulated toward a match, saturating at MAXLEN.

Function
REQ-017 SHALL keep a history window of the last MAXLEN valid digits; on each in_valid=1 cycle, shift number in as the newest digit.
REQ-018 SHALL evaluate a match on each in_valid=1 cycle:
  - the newest len digits, including the current one, equal pat[0..len-1] in order (pat[len-1] = current digit);
  - and fill+1 >= len.
REQ-019 SHALL assert pattern=1 in the cycle after the rising edge that sampled the completing digit, for exactly one cycle; otherwise pattern=0.
REQ-020 SHALL ignore number and hold history and fill when in_valid=0; pattern=0 in the following cycle.
REQ-021 SHALL, in overlapping mode, keep fill saturating on a match so that suffix-sharing matches are detected.
REQ-022 SHALL, in non-overlapping mode, set fill to 0 on a match so that no digit of a matched sequence contributes to a later match.
REQ-023 SHALL, on cfg_we=1, perform the following updates:
  - write pat[cfg_idx]=cfg_digit;
  - load len = cfg_len clamped to 1..MAXLEN (0 becomes 1; values above MAXLEN become MAXLEN);
  - load mode = cfg_overlap;
  - set fill=0.
REQ-024 SHALL give cfg_we priority when cfg_we and in_valid are both 1: the digit is dropped, there is no match, and fill=0.
REQ-025 SHALL increment match_count by 1 on each match and hold it at all-ones (2^CNTW-1) when saturated.
REQ-026 SHALL give cnt_clr priority over a same-cycle match: match_count=0, and the pattern pulse still occurs.
REQ-027 SHALL keep pattern, match_count and fill registered, with no combinational path from inputs to outputs.

Reset
REQ-028 SHALL, while reset=1 and asynchronously, set the following:
  - pattern=0, match_count=0, fill=0;
  - history all 0;
  - len=4, mode=overlapping;
  - pat[0..3]={1,0,9,4}, other slots 0.
REQ-029 SHALL resume operation on the first rising edge after reset deasserts; a reset during a partial match discards it.

Verification
REQ-030 SHALL cover the following directed scenarios:
  - Reset defaults, stream 7,5,1,0,9,4,1,0,9,4,3,1,0,9,2,1,0,9,4,8 -> pattern pulses after the digits at indexes 5, 9 and 18; match_count=3.
  - Configure len=3, pat={1,1,1}, overlap=1; stream 1,1,1,1,1 -> 3 pulses, match_count=3.
  - Same pattern with overlap=0; stream 1,1,1,1,1,1 -> pulses after the 3rd and 6th digits only; match_count=2.
  - Stream 1,0,9 with in_valid=0 gaps between digits, then 4 -> exactly one pulse after the 4; gaps produce no pulse.
  - Stream 1,0,9, assert reset, then 4 -> no pulse; fill=1 after the 4.
  - CNTW=2, 5 matches -> match_count stops at 3; cnt_clr in a match cycle -> match_count=0 and pattern=1.

Source files
------------

// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
// Programmable digit-sequence detector. A history window of the last MAXLEN
// valid digits is compared against a programmable pattern of 1..MAXLEN
// digits. Matches produce a registered one-cycle pulse and bump a saturating
// counter. Overlapping or non-overlapping detection is selectable.
//
// Ports
//   clock        : rising-edge clock
//   reset        : asynchronous active-high reset
//   in_valid     : qualifies number
//   number       : input digit (DW bits)
//   cfg_we       : configuration write strobe (wins over in_valid)
//   cfg_idx      : pattern slot written (slot 0 = oldest digit)
//   cfg_digit    : digit written to slot cfg_idx
//   cfg_len      : pattern length, clamped to 1..MAXLEN
//   cfg_overlap  : 1 = overlapping, 0 = non-overlapping
//   cnt_clr      : synchronous clear of match_count (wins over a match)
//   pattern      : registered one-cycle match pulse
//   match_count  : saturating match counter
//   fill         : digits accumulated toward a match, saturating at MAXLEN
// -----------------------------------------------------------------------------
module seq_detector_param #(
    parameter int DW     = 4,
    parameter int MAXLEN = 8,
    parameter int CNTW   = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [DW-1:0]             number,
    input  logic                      cfg_we,
    input  logic [$clog2(MAXLEN)-1:0] cfg_idx,
    input  logic [DW-1:0]             cfg_digit,
    input  logic [$clog2(MAXLEN):0]   cfg_len,
    input  logic                      cfg_overlap,
    input  logic                      cnt_clr,
    output logic                      pattern,
    output logic [CNTW-1:0]           match_count,
    output logic [$clog2(MAXLEN):0]   fill
);

    localparam int IW = $clog2(MAXLEN);
    localparam int LW = IW + 1;

    logic [DW-1:0]   hist_r   [MAXLEN];   // hist_r[0] is the newest stored digit
    logic [DW-1:0]   pat_r    [MAXLEN];
    logic [DW-1:0]   window_s [MAXLEN];   // window_s[0] is the digit arriving now
    logic [LW-1:0]   len_r;
    logic [LW-1:0]   fill_r;
    logic            mode_r;
    logic            pattern_r;
    logic [CNTW-1:0] count_r;

    logic [IW-1:0]   slot_s;
    logic            digits_eq_s;
    logic            enough_s;
    logic            match_s;
    logic [LW-1:0]   len_clamp_s;
    logic [LW-1:0]   fill_inc_s;

    assign pattern     = pattern_r;
    assign match_count = count_r;
    assign fill        = fill_r;

    // Candidate window: the current digit followed by the stored history.
    always_comb begin
        window_s[0] = number;
        for (int k = 1; k < MAXLEN; k++) begin
            window_s[k] = hist_r[k-1];
        end
    end

    // Compare the newest len digits against pat[len-1] down to pat[0].
    always_comb begin
        digits_eq_s = 1'b1;
        slot_s      = '0;
        for (int k = 0; k < MAXLEN; k++) begin
            if (k < int'(len_r)) begin
                slot_s = IW'(int'(len_r) - 1 - k);
                if (window_s[k] != pat_r[slot_s]) begin
                    digits_eq_s = 1'b0;
                end else begin
                    digits_eq_s = digits_eq_s;
                end
            end else begin
                digits_eq_s = digits_eq_s;
            end
        end
    end

    // Enough digits accumulated (fill + 1 >= len) and final match qualification.
    always_comb begin
        enough_s = (({1'b0, fill_r} + {{LW{1'b0}}, 1'b1}) >= {1'b0, len_r});
        if (in_valid && !cfg_we && digits_eq_s && enough_s) begin
            match_s = 1'b1;
        end else begin
            match_s = 1'b0;
        end
    end

    // Length clamp to 1..MAXLEN and saturating fill increment.
    always_comb begin
        if (cfg_len == {LW{1'b0}}) begin
            len_clamp_s = LW'(1);
        end else if (cfg_len > LW'(MAXLEN)) begin
            len_clamp_s = LW'(MAXLEN);
        end else begin
            len_clamp_s = cfg_len;
        end
        if (fill_r == LW'(MAXLEN)) begin
            fill_inc_s = fill_r;
        end else begin
            fill_inc_s = fill_r + LW'(1);
        end
    end

    // Configuration registers: pattern slots, length and detection mode.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MAXLEN; i++) begin
                pat_r[i] <= '0;
            end
            pat_r[0] <= DW'(4'd1);
            pat_r[1] <= DW'(4'd0);
            pat_r[2] <= DW'(4'd9);
            pat_r[3] <= DW'(4'd4);
            len_r    <= LW'(4);
            mode_r   <= 1'b1;
        end else if (cfg_we) begin
            pat_r[cfg_idx] <= cfg_digit;
            len_r          <= len_clamp_s;
            mode_r         <= cfg_overlap;
        end else begin
            len_r  <= len_r;
            mode_r <= mode_r;
        end
    end

    // History shift register; a configuration write drops the digit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MAXLEN; i++) begin
                hist_r[i] <= '0;
            end
        end else if (in_valid && !cfg_we) begin
            hist_r[0] <= number;
            for (int i = 1; i < MAXLEN; i++) begin
                hist_r[i] <= hist_r[i-1];
            end
        end else begin
            for (int i = 0; i < MAXLEN; i++) begin
                hist_r[i] <= hist_r[i];
            end
        end
    end

    // Fill tracking: non-overlapping matches consume their digits.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fill_r <= '0;
        end else if (cfg_we) begin
            fill_r <= '0;
        end else if (in_valid) begin
            if (match_s && !mode_r) begin
                fill_r <= '0;
            end else begin
                fill_r <= fill_inc_s;
            end
        end else begin
            fill_r <= fill_r;
        end
    end

    // Match pulse and saturating counter; clear beats a same-cycle match.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pattern_r <= 1'b0;
            count_r   <= '0;
        end else begin
            pattern_r <= match_s;
            if (cnt_clr) begin
                count_r <= '0;
            end else if (match_s && (count_r != {CNTW{1'b1}})) begin
                count_r <= count_r + CNTW'(1);
            end else begin
                count_r <= count_r;
            end
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

    localparam int DW     = 4;
    localparam int MAXLEN = 8;

    logic       clock;
    logic       reset;
    logic       in_valid;
    logic [3:0] number;
    logic       cfg_we;
    logic [2:0] cfg_idx;
    logic [3:0] cfg_digit;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic       cnt_clr;
    logic       pattern_a, pattern_b;
    logic [7:0] count_a;
    logic [1:0] count_b;
    logic [3:0] fill_a, fill_b;

    seq_detector_param #(.DW(4), .MAXLEN(8), .CNTW(8)) dut_a (
        .clock(clock), .reset(reset), .in_valid(in_valid), .number(number),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_digit(cfg_digit),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .pattern(pattern_a), .match_count(count_a), .fill(fill_a));

    seq_detector_param #(.DW(4), .MAXLEN(8), .CNTW(2)) dut_b (
        .clock(clock), .reset(reset), .in_valid(in_valid), .number(number),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_digit(cfg_digit),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .pattern(pattern_b), .match_count(count_b), .fill(fill_b));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic p;
        int   c8;
        int   c2;
        int   f;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: digits eligible for a match since the last restart
    int   elig[$];
    int   pat_m[MAXLEN];
    int   len_m;
    bit   ovl_m;
    int   c8_m, c2_m;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        elig.delete();
        for (int i = 0; i < MAXLEN; i++) pat_m[i] = 0;
        pat_m[0] = 1; pat_m[1] = 0; pat_m[2] = 9; pat_m[3] = 4;
        len_m = 4; ovl_m = 1'b1; c8_m = 0; c2_m = 0;
    endtask

    // One clock of stimulus; the model's expected outputs go to the scoreboard.
    task automatic step(input bit v, input int num, input bit we = 1'b0,
                        input int idx = 0, input int dig = 0, input int clen = 0,
                        input bit ov = 1'b0, input bit clr = 1'b0, input bit rst = 1'b0);
        exp_t e;
        bit   m;
        @(negedge clock);
        reset = rst; in_valid = v; number = num[3:0]; cfg_we = we;
        cfg_idx = idx[2:0]; cfg_digit = dig[3:0]; cfg_len = clen[3:0];
        cfg_overlap = ov; cnt_clr = clr;
        m = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            if (we) begin
                pat_m[idx] = dig;
                len_m = (clen == 0) ? 1 : ((clen > MAXLEN) ? MAXLEN : clen);
                ovl_m = ov;
                elig.delete();
            end else if (v) begin
                elig.push_back(num);
                if (elig.size() >= len_m) begin
                    m = 1'b1;
                    for (int k = 0; k < len_m; k++)
                        if (elig[elig.size() - len_m + k] != pat_m[k]) m = 1'b0;
                end
                if (m && !ovl_m) elig.delete();
                if (elig.size() > MAXLEN) void'(elig.pop_front());
            end
            if (clr) begin
                c8_m = 0; c2_m = 0;
            end else if (m) begin
                if (c8_m < 255) c8_m++;
                if (c2_m < 3) c2_m++;
            end
        end
        e.p = m; e.c8 = c8_m; e.c2 = c2_m; e.f = elig.size();
        exp_q.push_back(e);
        @(posedge clock);
    endtask

    // Scoreboard monitor: pops one expectation per clock once stimulus is queued.
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pattern_a", int'(pattern_a), int'(e.p));
            chk("pattern_b", int'(pattern_b), int'(e.p));
            chk("count_a", int'(count_a), e.c8);
            chk("count_b", int'(count_b), e.c2);
            chk("fill_a", int'(fill_a), e.f);
            chk("fill_b", int'(fill_b), e.f);
        end
    end

    task automatic stream(input int d[$]);
        foreach (d[i]) step(1'b1, d[i]);
    endtask

    initial begin
        int s1[$];
        int r;
        reset = 1'b1; in_valid = 1'b0; number = '0; cfg_we = 1'b0;
        cfg_idx = '0; cfg_digit = '0; cfg_len = '0; cfg_overlap = 1'b0; cnt_clr = 1'b0;
        model_reset();

        // Reset defaults
        step(1'b0, 0, .rst(1'b1));
        step(1'b0, 0, .rst(1'b1));
        #2;
        chk("reset_fill", int'(fill_a), 0);
        chk("reset_count", int'(count_a), 0);

        // Default pattern 1,0,9,4
        s1 = '{7,5,1,0,9,4,1,0,9,4,3,1,0,9,2,1,0,9,4,8};
        stream(s1);
        #2;
        chk("s1_count", int'(count_a), 3);

        // Overlapping 1,1,1
        step(1'b0, 0, 1'b1, 0, 1, 3, 1'b1);
        step(1'b0, 0, 1'b1, 1, 1, 3, 1'b1);
        step(1'b0, 0, 1'b1, 2, 1, 3, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1);
        #2;
        chk("s2_count_a", int'(count_a), 6);
        chk("s2_count_b_sat", int'(count_b), 3);

        // Non-overlapping 1,1,1
        step(1'b0, 0, .clr(1'b1));
        step(1'b0, 0, 1'b1, 0, 1, 3, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1);
        #2;
        chk("s3_count", int'(count_a), 2);

        // Restore 1,0,9,4 and stream with gaps
        step(1'b0, 0, 1'b1, 0, 1, 4, 1'b1);
        step(1'b0, 0, 1'b1, 1, 0, 4, 1'b1);
        step(1'b0, 0, 1'b1, 2, 9, 4, 1'b1);
        step(1'b0, 0, 1'b1, 3, 4, 4, 1'b1);
        step(1'b1, 1); step(1'b0, 0); step(1'b1, 0); step(1'b0, 0);
        step(1'b0, 0); step(1'b1, 9); step(1'b0, 0); step(1'b1, 4);
        #2;
        chk("s4_pulse", int'(pattern_a), 1);
        chk("s4_count", int'(count_a), 3);

        // Reset mid-match discards it
        step(1'b1, 1); step(1'b1, 0); step(1'b1, 9);
        step(1'b0, 0, .rst(1'b1));
        step(1'b1, 4);
        #2;
        chk("s5_no_pulse", int'(pattern_a), 0);
        chk("s5_fill", int'(fill_a), 1);

        // Clear in a match cycle
        step(1'b1, 1); step(1'b1, 0); step(1'b1, 9);
        step(1'b1, 4, .clr(1'b1));
        #2;
        chk("s6_pulse", int'(pattern_a), 1);
        chk("s6_count_a", int'(count_a), 0);
        chk("s6_count_b", int'(count_b), 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 299);
            if (r == 0) begin
                step(1'b0, 0, .rst(1'b1));
            end else if (r < 8) begin
                step($urandom_range(0, 1) == 1, $urandom_range(0, 15), 1'b1,
                     $urandom_range(0, 7), $urandom_range(0, 3),
                     $urandom_range(0, 10), $urandom_range(0, 1) == 1);
            end else begin
                int d;
                if ($urandom_range(0, 9) < 7) d = pat_m[$urandom_range(0, len_m - 1)];
                else d = $urandom_range(0, 15);
                step($urandom_range(0, 3) != 0, d, .clr($urandom_range(0, 99) < 2));
            end
        end

        @(negedge clock);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
